// File: rtl/branch_ctrl_seq_pkg.sv
// Shared types for the branch control sequencer: FSM state encoding and datapath strobe bundle.
// Opcode default is the branch class (brzr/brnz/brpl/brmi share IR[31:27]).
package branch_ctrl_pkg;

    localparam logic [4:0] BR_OPCODE_DEF = 5'b10010;

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        T0    = 4'd1,
        T1    = 4'd2,
        T2    = 4'd3,
        T3    = 4'd4,
        T4    = 4'd5,
        T5    = 4'd6,
        T6    = 4'd7,
        DEC   = 4'd8,
        DONE  = 4'd9,
        FAULT = 4'd10
    } state_e;

    typedef struct packed {
        logic pc_out;
        logic mar_in;
        logic inc_pc;
        logic z_in;
        logic read;
        logic mdr_in;
        logic pc_in;
        logic zlo_out;
        logic mdr_out;
        logic ir_in;
        logic gra;
        logic r_out;
        logic con_in;
        logic y_in;
        logic c_out;
    } strobe_t;

endpackage

// File: rtl/branch_ctrl_seq_mem_wait_timer.sv
// Memory-wait counter: clear has priority over enable; expired while the count sits at all-ones.
// One-cycle update latency, no backpressure.
module mem_wait_timer #(
    parameter int unsigned TIMEOUT_W = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 clr_i,
    input  logic                 en_i,
    output logic [TIMEOUT_W-1:0] count_o,
    output logic                 expired_o
);

    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_o   = cnt_q;
    assign expired_o = (cnt_q == {TIMEOUT_W{1'b1}});

endmodule

// File: rtl/branch_ctrl_seq.sv
// Moore control sequencer for fetch + conditional branch; Done/Illegal pulse in the DONE slot.
// Optional branch statistics counters are built only when BRANCH_STATS_EN is defined.
module branch_ctrl_seq
    import branch_ctrl_pkg::*;
#(
    parameter int unsigned        OPCODE_W  = 5,
    parameter logic [OPCODE_W-1:0] BR_OPCODE = BR_OPCODE_DEF,
    parameter int unsigned        TIMEOUT_W = 4,
    parameter int unsigned        STAT_W    = 16
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                run_i,
    input  logic [OPCODE_W-1:0] opcode_i,
    input  logic                con_i,
    input  logic                mem_ready_i,
    output logic                pc_out_o,
    output logic                mar_in_o,
    output logic                inc_pc_o,
    output logic                z_in_o,
    output logic                read_o,
    output logic                mdr_in_o,
    output logic                pc_in_o,
    output logic                zlo_out_o,
    output logic                mdr_out_o,
    output logic                ir_in_o,
    output logic                gra_o,
    output logic                r_out_o,
    output logic                con_in_o,
    output logic                y_in_o,
    output logic                c_out_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                illegal_o,
    output logic                fault_o,
    output logic [STAT_W-1:0]   taken_count_o,
    output logic [STAT_W-1:0]   not_taken_count_o
);

    state_e  state_q, state_d;
    logic    illegal_q, illegal_d;
    strobe_t strb;
    logic    busy, done, illegal, fault;

    logic                 wait_clr, wait_en, wait_expired;
    logic [TIMEOUT_W-1:0] wait_cnt;

    assign wait_clr = (state_q != T1);
    assign wait_en  = (state_q == T1) && !mem_ready_i;

    mem_wait_timer #(
        .TIMEOUT_W (TIMEOUT_W)
    ) u_wait (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .clr_i     (wait_clr),
        .en_i      (wait_en),
        .count_o   (wait_cnt),
        .expired_o (wait_expired)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        strb      = '0;
        busy      = 1'b1;
        done      = 1'b0;
        illegal   = 1'b0;
        fault     = 1'b0;
        case (state_q)
            IDLE: begin
                busy      = 1'b0;
                illegal_d = 1'b0;
                if (run_i) state_d = T0;
            end
            T0: begin
                strb.pc_out = 1'b1;
                strb.mar_in = 1'b1;
                strb.inc_pc = 1'b1;
                strb.z_in   = 1'b1;
                state_d     = T1;
            end
            T1: begin
                strb.read   = 1'b1;
                strb.mdr_in = 1'b1;
                // A zero wait count marks the first T1 cycle; PC is written back only once.
                if (wait_cnt == '0) begin
                    strb.pc_in   = 1'b1;
                    strb.zlo_out = 1'b1;
                end
                if (mem_ready_i) begin
                    state_d = T2;
                end else if (wait_expired) begin
                    state_d = FAULT;
                end
            end
            T2: begin
                strb.mdr_out = 1'b1;
                strb.ir_in   = 1'b1;
                state_d      = DEC;
            end
            DEC: begin
                if (opcode_i == BR_OPCODE) begin
                    state_d = T3;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = DONE;
                end
            end
            T3: begin
                strb.gra    = 1'b1;
                strb.r_out  = 1'b1;
                strb.con_in = 1'b1;
                state_d     = T4;
            end
            T4: begin
                strb.pc_out = 1'b1;
                strb.y_in   = 1'b1;
                state_d     = con_i ? T5 : DONE;
            end
            T5: begin
                strb.c_out = 1'b1;
                strb.z_in  = 1'b1;
                state_d    = T6;
            end
            T6: begin
                strb.zlo_out = 1'b1;
                strb.pc_in   = 1'b1;
                state_d      = DONE;
            end
            DONE: begin
                done      = 1'b1;
                illegal   = illegal_q;
                illegal_d = 1'b0;
                // An illegal opcode always parks the sequencer, even with Run held high.
                state_d   = (run_i && !illegal_q) ? T0 : IDLE;
            end
            FAULT: begin
                busy  = 1'b0;
                fault = 1'b1;
            end
            default: begin
                busy    = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign pc_out_o  = strb.pc_out;
    assign mar_in_o  = strb.mar_in;
    assign inc_pc_o  = strb.inc_pc;
    assign z_in_o    = strb.z_in;
    assign read_o    = strb.read;
    assign mdr_in_o  = strb.mdr_in;
    assign pc_in_o   = strb.pc_in;
    assign zlo_out_o = strb.zlo_out;
    assign mdr_out_o = strb.mdr_out;
    assign ir_in_o   = strb.ir_in;
    assign gra_o     = strb.gra;
    assign r_out_o   = strb.r_out;
    assign con_in_o  = strb.con_in;
    assign y_in_o    = strb.y_in;
    assign c_out_o   = strb.c_out;
    assign busy_o    = busy;
    assign done_o    = done;
    assign illegal_o = illegal;
    assign fault_o   = fault;

`ifdef BRANCH_STATS_EN
    logic [STAT_W-1:0] taken_q, not_taken_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            taken_q     <= '0;
            not_taken_q <= '0;
        end else if (state_q == T4) begin
            if (con_i && (taken_q != {STAT_W{1'b1}})) begin
                taken_q <= taken_q + 1'b1;
            end
            if (!con_i && (not_taken_q != {STAT_W{1'b1}})) begin
                not_taken_q <= not_taken_q + 1'b1;
            end
        end
    end

    assign taken_count_o     = taken_q;
    assign not_taken_count_o = not_taken_q;
`else
    assign taken_count_o     = '0;
    assign not_taken_count_o = '0;
`endif

endmodule

// File: tb/tb_branch_ctrl_seq.sv
// Directed bench for branch_ctrl_seq with a tiny PC/Y/Z datapath model driven by the strobes.
module tb_branch_ctrl_seq;

    localparam logic [14:0] S_NONE = 15'b000000000000000;
    localparam logic [14:0] S_T0   = 15'b111100000000000;
    localparam logic [14:0] S_T1F  = 15'b000011110000000;
    localparam logic [14:0] S_T1W  = 15'b000011000000000;
    localparam logic [14:0] S_T2   = 15'b000000001100000;
    localparam logic [14:0] S_T3   = 15'b000000000011100;
    localparam logic [14:0] S_T4   = 15'b100000000000010;
    localparam logic [14:0] S_T5   = 15'b000100000000001;
    localparam logic [14:0] S_T6   = 15'b000000110000000;
    localparam logic [4:0]  OP_BR  = 5'b10010;
    localparam logic [4:0]  OP_ADD = 5'b00011;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        run_i;
    logic [4:0]  opcode_i;
    logic        con_i;
    logic        mem_ready_i;
    logic        pc_out_o, mar_in_o, inc_pc_o, z_in_o, read_o, mdr_in_o, pc_in_o, zlo_out_o;
    logic        mdr_out_o, ir_in_o, gra_o, r_out_o, con_in_o, y_in_o, c_out_o;
    logic        busy_o, done_o, illegal_o, fault_o;
    logic [15:0] taken_count_o, not_taken_count_o;
    logic [14:0] strb;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] pc_m, y_m, z_m, c_m, r6_m;
    logic        pat [5];

    always #5 clk_i = ~clk_i;

    branch_ctrl_seq dut (
        .clk_i             (clk_i),
        .rst_n_i           (rst_n_i),
        .run_i             (run_i),
        .opcode_i          (opcode_i),
        .con_i             (con_i),
        .mem_ready_i       (mem_ready_i),
        .pc_out_o          (pc_out_o),
        .mar_in_o          (mar_in_o),
        .inc_pc_o          (inc_pc_o),
        .z_in_o            (z_in_o),
        .read_o            (read_o),
        .mdr_in_o          (mdr_in_o),
        .pc_in_o           (pc_in_o),
        .zlo_out_o         (zlo_out_o),
        .mdr_out_o         (mdr_out_o),
        .ir_in_o           (ir_in_o),
        .gra_o             (gra_o),
        .r_out_o           (r_out_o),
        .con_in_o          (con_in_o),
        .y_in_o            (y_in_o),
        .c_out_o           (c_out_o),
        .busy_o            (busy_o),
        .done_o            (done_o),
        .illegal_o         (illegal_o),
        .fault_o           (fault_o),
        .taken_count_o     (taken_count_o),
        .not_taken_count_o (not_taken_count_o)
    );

    assign strb = {pc_out_o, mar_in_o, inc_pc_o, z_in_o, read_o, mdr_in_o, pc_in_o, zlo_out_o,
                   mdr_out_o, ir_in_o, gra_o, r_out_o, con_in_o, y_in_o, c_out_o};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply the current cycle's strobes to the datapath model, then advance one clock.
    task automatic tick();
        if (pc_out_o && inc_pc_o && z_in_o) z_m = pc_m + 32'd1;
        if (c_out_o && z_in_o)              z_m = y_m + c_m;
        if (zlo_out_o && pc_in_o)           pc_m = z_m;
        if (pc_out_o && y_in_o)             y_m = pc_m;
        @(posedge clk_i);
        #1;
    endtask

    task automatic step_chk(input string tag, input logic [14:0] s, input logic d);
        tick();
        chk({tag, "_strb"}, {17'd0, strb}, {17'd0, s});
        chk({tag, "_done"}, {31'd0, done_o}, {31'd0, d});
    endtask

    initial begin
        rst_n_i     = 1'b0;
        run_i       = 1'b0;
        opcode_i    = OP_BR;
        con_i       = 1'b0;
        mem_ready_i = 1'b1;
        pc_m = 32'd0; y_m = 32'd0; z_m = 32'd0; c_m = 32'd0; r6_m = 32'd0;
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1; pat[3] = 1'b0; pat[4] = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_strb", {17'd0, strb}, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_done", {31'd0, done_o}, 32'd0);
        chk("rst_fault", {31'd0, fault_o}, 32'd0);
        chk("rst_illegal", {31'd0, illegal_o}, 32'd0);
        chk("rst_taken", {16'd0, taken_count_o}, 32'd0);
        chk("rst_ntaken", {16'd0, not_taken_count_o}, 32'd0);
        #2 rst_n_i = 1'b1;
        tick();

        // brmi R6,25 with R6 negative: taken, PC 12 -> 13 -> 38, Done on cycle 9.
        pc_m = 32'd12; c_m = 32'd25; r6_m = 32'h8000_0000;
        con_i = r6_m[31];
        run_i = 1'b1;
        step_chk("tk_c1", S_T0, 1'b0);
        chk("tk_busy", {31'd0, busy_o}, 32'd1);
        run_i = 1'b0;
        step_chk("tk_c2", S_T1F, 1'b0);
        step_chk("tk_c3", S_T2, 1'b0);
        step_chk("tk_c4", S_NONE, 1'b0);
        step_chk("tk_c5", S_T3, 1'b0);
        step_chk("tk_c6", S_T4, 1'b0);
        step_chk("tk_c7", S_T5, 1'b0);
        step_chk("tk_c8", S_T6, 1'b0);
        step_chk("tk_c9", S_NONE, 1'b1);
        chk("tk_illegal", {31'd0, illegal_o}, 32'd0);
        tick();
        chk("tk_pc", pc_m, 32'd38);
        chk("tk_idle_busy", {31'd0, busy_o}, 32'd0);
        chk("tk_idle_done", {31'd0, done_o}, 32'd0);

        // Same instruction, R6 = 0: not taken, Done on cycle 7, PC ends at 13.
        pc_m = 32'd12; r6_m = 32'd0;
        con_i = r6_m[31];
        run_i = 1'b1;
        step_chk("nt_c1", S_T0, 1'b0);
        run_i = 1'b0;
        step_chk("nt_c2", S_T1F, 1'b0);
        step_chk("nt_c3", S_T2, 1'b0);
        step_chk("nt_c4", S_NONE, 1'b0);
        step_chk("nt_c5", S_T3, 1'b0);
        step_chk("nt_c6", S_T4, 1'b0);
        step_chk("nt_c7", S_NONE, 1'b1);
        tick();
        chk("nt_pc", pc_m, 32'd13);
        chk("nt_idle_busy", {31'd0, busy_o}, 32'd0);

        // MemReady low for the first three T1 cycles: T1 lasts four cycles.
        mem_ready_i = 1'b0;
        run_i = 1'b1;
        step_chk("mw_t0", S_T0, 1'b0);
        run_i = 1'b0;
        step_chk("mw_t1a", S_T1F, 1'b0);
        step_chk("mw_t1b", S_T1W, 1'b0);
        step_chk("mw_t1c", S_T1W, 1'b0);
        step_chk("mw_t1d", S_T1W, 1'b0);
        mem_ready_i = 1'b1;
        step_chk("mw_t2", S_T2, 1'b0);
        step_chk("mw_dec", S_NONE, 1'b0);
        step_chk("mw_t3", S_T3, 1'b0);
        step_chk("mw_t4", S_T4, 1'b0);
        step_chk("mw_done", S_NONE, 1'b1);
        chk("mw_fault", {31'd0, fault_o}, 32'd0);
        tick();

        // MemReady stuck low: FAULT 16 cycles after T1 entry, sticky until reset.
        mem_ready_i = 1'b0;
        run_i = 1'b1;
        step_chk("to_t0", S_T0, 1'b0);
        run_i = 1'b0;
        step_chk("to_t1f", S_T1F, 1'b0);
        for (int i = 1; i <= 15; i++) begin
            step_chk($sformatf("to_w%0d", i), S_T1W, 1'b0);
            chk($sformatf("to_w%0d_fault", i), {31'd0, fault_o}, 32'd0);
        end
        step_chk("to_fault", S_NONE, 1'b0);
        chk("to_fault_flag", {31'd0, fault_o}, 32'd1);
        chk("to_fault_busy", {31'd0, busy_o}, 32'd0);
        run_i = 1'b1; mem_ready_i = 1'b1;
        step_chk("to_stick1", S_NONE, 1'b0);
        step_chk("to_stick2", S_NONE, 1'b0);
        chk("to_sticky", {31'd0, fault_o}, 32'd1);
        run_i = 1'b0;
        #2 rst_n_i = 1'b0;
        #1;
        chk("to_rst_fault", {31'd0, fault_o}, 32'd0);
        chk("to_rst_taken", {16'd0, taken_count_o}, 32'd0);
        chk("to_rst_ntaken", {16'd0, not_taken_count_o}, 32'd0);
        #3 rst_n_i = 1'b1;
        tick();

        // Non-branch opcode: Illegal with Done after DEC, five cycles, then IDLE.
        opcode_i = OP_ADD;
        run_i = 1'b1;
        step_chk("il_c1", S_T0, 1'b0);
        run_i = 1'b0;
        step_chk("il_c2", S_T1F, 1'b0);
        step_chk("il_c3", S_T2, 1'b0);
        step_chk("il_c4", S_NONE, 1'b0);
        chk("il_c4_illegal", {31'd0, illegal_o}, 32'd0);
        step_chk("il_c5", S_NONE, 1'b1);
        chk("il_c5_illegal", {31'd0, illegal_o}, 32'd1);
        tick();
        chk("il_idle_busy", {31'd0, busy_o}, 32'd0);
        chk("il_idle_illegal", {31'd0, illegal_o}, 32'd0);
        opcode_i = OP_BR;

        // Back-to-back issue with Run held: taken/not-taken pattern 1,0,1,0,1.
        run_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            con_i = pat[k];
            step_chk($sformatf("bb%0d_t0", k), S_T0, 1'b0);
            step_chk($sformatf("bb%0d_t1", k), S_T1F, 1'b0);
            step_chk($sformatf("bb%0d_t2", k), S_T2, 1'b0);
            step_chk($sformatf("bb%0d_dec", k), S_NONE, 1'b0);
            step_chk($sformatf("bb%0d_t3", k), S_T3, 1'b0);
            step_chk($sformatf("bb%0d_t4", k), S_T4, 1'b0);
            if (pat[k]) begin
                step_chk($sformatf("bb%0d_t5", k), S_T5, 1'b0);
                step_chk($sformatf("bb%0d_t6", k), S_T6, 1'b0);
            end
            step_chk($sformatf("bb%0d_done", k), S_NONE, 1'b1);
            if (k == 4) run_i = 1'b0;
        end
        tick();
        chk("bb_idle_busy", {31'd0, busy_o}, 32'd0);
`ifdef BRANCH_STATS_EN
        chk("bb_taken", {16'd0, taken_count_o}, 32'd3);
        chk("bb_ntaken", {16'd0, not_taken_count_o}, 32'd2);
`else
        chk("bb_taken", {16'd0, taken_count_o}, 32'd0);
        chk("bb_ntaken", {16'd0, not_taken_count_o}, 32'd0);
`endif

        // Asynchronous reset mid-T5, then a clean restart.
        con_i = 1'b1;
        run_i = 1'b1;
        step_chk("ar_t0", S_T0, 1'b0);
        run_i = 1'b0;
        step_chk("ar_t1", S_T1F, 1'b0);
        step_chk("ar_t2", S_T2, 1'b0);
        step_chk("ar_dec", S_NONE, 1'b0);
        step_chk("ar_t3", S_T3, 1'b0);
        step_chk("ar_t4", S_T4, 1'b0);
        step_chk("ar_t5", S_T5, 1'b0);
        #2 rst_n_i = 1'b0;
        #1;
        chk("ar_strb", {17'd0, strb}, 32'd0);
        chk("ar_busy", {31'd0, busy_o}, 32'd0);
        chk("ar_done", {31'd0, done_o}, 32'd0);
        chk("ar_taken", {16'd0, taken_count_o}, 32'd0);
        chk("ar_ntaken", {16'd0, not_taken_count_o}, 32'd0);
        #1 rst_n_i = 1'b1;
        run_i = 1'b1;
        step_chk("ar_re_t0", S_T0, 1'b0);
        run_i = 1'b0;
        step_chk("ar_re_t1", S_T1F, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
